tcdm_addr_demux: RTL
====================

// Module: tcdm_addr_demux
// PURPOSE
// - Request demultiplexer sitting directly downstream of the static-rule address decoder.
// - Takes one TCDM-style master request plus the decoder's index/error result.
// - Steers the request to one of NoPorts slave ports and merges the slave responses back in request order.
// - Answers decode errors locally with an error response; no slave port is touched.
// - Tracks outstanding transactions so responses are never reordered across ports.
// PARAMETERS
// NoPorts    4   number of slave ports; decoder idx range is 0..NoPorts-1
// AddrWidth  32  request address width
// DataWidth  32  data width; byte enable width is DataWidth/8
// MaxTrans   8   max outstanding transactions (>=1); counter width $clog2(MaxTrans+1)
// IdxWidth   (NoPorts>1)?$clog2(NoPorts):1   derived, do not override
// PORTS
// clk_i            in   1                  clock, single domain
// rst_ni           in   1                  asynchronous active-low reset
// req_valid_i      in   1                  master request valid
// req_ready_o      out  1                  master request accepted this cycle
// req_addr_i       in   AddrWidth          request address (also fed to decoder)
// req_we_i         in   1                  1=write, 0=read
// req_wdata_i      in   DataWidth          write data
// req_be_i         in   DataWidth/8        byte enables
// dec_idx_i        in   IdxWidth           decoder idx_o for req_addr_i
// dec_error_i      in   1                  decoder dec_error_o (no rule matched, no default)
// slv_req_valid_o  out  NoPorts            one-hot request valid per slave
// slv_req_ready_i  in   NoPorts            per-slave ready
// slv_addr_o, slv_we_o, slv_wdata_o, slv_be_o  out  as req_*   broadcast copy of master fields
// slv_rsp_valid_i  in   NoPorts            per-slave response valid (no back-pressure)
// slv_rsp_rdata_i  in   NoPorts*DataWidth  per-slave read data, port p at [p*DataWidth +: DataWidth]
// rsp_valid_o      out  1                  registered response to master
// rsp_rdata_o      out  DataWidth          response data; 0 on error
// rsp_error_o      out  1                  response belongs to a decode-error request
// busy_o           out  1                  outstanding count != 0
// BEHAVIOUR
// - Target: tgt = dec_error_i ? ERR : dec_idx_i; ERR is a virtual port NoPorts.
// - State registers: cur_tgt (IdxWidth+1 bits), cnt (outstanding count), err_pend (1 bit).
// - Request issue is allowed when req_valid_i && (cnt==0 || tgt==cur_tgt) && cnt<MaxTrans.
// - Slave request, when allowed and tgt<NoPorts:
//   - slv_req_valid_o[tgt]=1; all other bits 0.
//   - req_ready_o = slv_req_ready_i[tgt], combinational pass-through, 0-cycle latency.
// - Error request, when allowed and tgt==ERR:
//   - req_ready_o=1; no slv_req_valid_o bit is set.
//   - err_pend<=1 for exactly one cycle.
// - When issue is blocked (port switch while cnt>0, or cnt==MaxTrans): req_ready_o=0 and slv_req_valid_o=0.
// - Accept (req_valid_i && req_ready_o): cur_tgt<=tgt and cnt increments.
// - Response capture, registered, 1-cycle latency:
//   - If err_pend: rsp_valid_o<=1, rsp_error_o<=1, rsp_rdata_o<=0, and cnt decrements.
//   - Else if cnt>0 && cur_tgt<NoPorts && slv_rsp_valid_i[cur_tgt]: rsp_valid_o<=1, rsp_error_o<=0, rdata<=that slice, and cnt decrements.
//   - Otherwise rsp_valid_o<=0.
//   - err_pend and a slave response cannot coincide, because cur_tgt==ERR blocks all slave issue.
// - slv_rsp_valid_i on a port other than cur_tgt, or while cnt==0, is dropped silently.
// - Accept and response in the same cycle: cnt is unchanged; cur_tgt updates per the accept rule.
// - cnt never wraps: it saturates by construction (issue is blocked at MaxTrans).
// - A decrement at cnt==0 is impossible, because responses are gated by cnt>0.
// - Port switch is permitted in the same cycle cnt reaches 0 only if cnt was already 0 at cycle start, since the condition uses registered cnt.
// - Reset values:
//   - cnt=0, cur_tgt=0, err_pend=0.
//   - rsp_valid_o=0, rsp_error_o=0, rsp_rdata_o=0, busy_o=0.
//   - slv_req_valid_o=0 while req_valid_i=0.
// - Reset mid-operation: all in-flight transactions are forgotten; late slave responses after reset are dropped (cnt==0).
// TESTING
// - Two reads to port 2, slave 2 ready, rsp rdata 0xA5 then 0x5A -> rsp_valid_o 1 cycle after each rsp_valid_i, rdata A5, 5A; cnt 0->1->2->1->0.
// - Read port 1 outstanding (cnt=1), then req to port 3 -> req_ready_o=0, slv_req_valid_o=0 until port-1 rsp; port-3 req issued the cycle after cnt==0.
// - dec_error_i=1 on idle demux -> req_ready_o=1 same cycle, no slv valid, 2 cycles later rsp_valid_o=1, rsp_error_o=1, rdata=0.
// - MaxTrans=8 back-to-back reads to port 0, no rsp -> 8 accepts, 9th held req_ready_o=0; one rsp frees a slot next cycle.
// - Accept and response in the same cycle at cnt=3 -> cnt stays 3; spurious slv_rsp_valid_i[1] while cur_tgt=0 -> no rsp_valid_o.
// - Assert rst_ni low with cnt=4 -> outputs 0 immediately; post-reset slv_rsp_valid_i[0] dropped; new port-2 req accepted at once.

Source files
------------

// File: rtl/tcdm_addr_demux.sv
// Steers one TCDM master request to one of NoPorts slaves (or a local error port)
// and returns responses in request order by allowing only one target in flight.
module tcdm_addr_demux #(
    parameter int unsigned NoPorts   = 4,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned MaxTrans  = 8,
    parameter int unsigned IdxWidth  = (NoPorts > 1) ? $clog2(NoPorts) : 1
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,

    input  logic                           req_valid_i,
    output logic                           req_ready_o,
    input  logic [AddrWidth-1:0]           req_addr_i,
    input  logic                           req_we_i,
    input  logic [DataWidth-1:0]           req_wdata_i,
    input  logic [DataWidth/8-1:0]         req_be_i,

    input  logic [IdxWidth-1:0]            dec_idx_i,
    input  logic                           dec_error_i,

    output logic [NoPorts-1:0]             slv_req_valid_o,
    input  logic [NoPorts-1:0]             slv_req_ready_i,
    output logic [AddrWidth-1:0]           slv_addr_o,
    output logic                           slv_we_o,
    output logic [DataWidth-1:0]           slv_wdata_o,
    output logic [DataWidth/8-1:0]         slv_be_o,
    input  logic [NoPorts-1:0]             slv_rsp_valid_i,
    input  logic [NoPorts*DataWidth-1:0]   slv_rsp_rdata_i,

    output logic                           rsp_valid_o,
    output logic [DataWidth-1:0]           rsp_rdata_o,
    output logic                           rsp_error_o,
    output logic                           busy_o
);

    localparam int unsigned TgtWidth = IdxWidth + 1;
    localparam int unsigned CntWidth = $clog2(MaxTrans + 1);

    // Target value NoPorts is the virtual port that answers decode errors locally.
    localparam logic [TgtWidth-1:0] TgtErr = TgtWidth'(NoPorts);
    localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxTrans);
    localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);

    logic [TgtWidth-1:0]  cur_tgt;
    logic [CntWidth-1:0]  cnt;
    logic                 err_pend;

    logic [TgtWidth-1:0]  tgt;
    logic                 tgt_is_err;
    logic                 issue_ok;
    logic                 slv_ready_sel;
    logic                 slv_rsp_hit;
    logic [DataWidth-1:0] slv_rdata_sel;
    logic                 accept;
    logic                 rsp_fire;

    // An index outside the port range is treated like a decode error so that
    // such a request can never hang waiting on a non-existent slave.
    always_comb begin
        tgt_is_err = dec_error_i || ({1'b0, dec_idx_i} >= TgtErr);
        tgt        = tgt_is_err ? TgtErr : {1'b0, dec_idx_i};
    end

    assign issue_ok = req_valid_i
                   && ((cnt == '0) || (tgt == cur_tgt))
                   && (cnt < CntMax);

    always_comb begin
        slv_req_valid_o = '0;
        slv_ready_sel   = 1'b0;
        slv_rsp_hit     = 1'b0;
        slv_rdata_sel   = '0;
        for (int p = 0; p < NoPorts; p++) begin
            if (tgt == TgtWidth'(p)) begin
                slv_req_valid_o[p] = issue_ok;
                slv_ready_sel      = slv_req_ready_i[p];
            end
            if (cur_tgt == TgtWidth'(p)) begin
                slv_rsp_hit   = slv_rsp_valid_i[p];
                slv_rdata_sel = slv_rsp_rdata_i[p*DataWidth +: DataWidth];
            end
        end
    end

    assign req_ready_o = issue_ok && (tgt_is_err || slv_ready_sel);
    assign accept      = req_valid_i && req_ready_o;

    // cur_tgt==ERR never matches a slave, so err_pend and a slave hit are exclusive.
    assign rsp_fire = err_pend || ((cnt != '0) && slv_rsp_hit);

    assign slv_addr_o  = req_addr_i;
    assign slv_we_o    = req_we_i;
    assign slv_wdata_o = req_wdata_i;
    assign slv_be_o    = req_be_i;

    assign busy_o = (cnt != '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cur_tgt     <= '0;
            cnt         <= '0;
            err_pend    <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_error_o <= 1'b0;
            rsp_rdata_o <= '0;
        end else begin
            err_pend <= accept && tgt_is_err;
            if (accept) begin
                cur_tgt <= tgt;
            end
            if (accept && !rsp_fire) begin
                cnt <= cnt + CntOne;
            end else if (!accept && rsp_fire) begin
                cnt <= cnt - CntOne;
            end
            rsp_valid_o <= rsp_fire;
            if (rsp_fire) begin
                rsp_error_o <= err_pend;
                rsp_rdata_o <= err_pend ? '0 : slv_rdata_sel;
            end
        end
    end

endmodule
